clint_icb_arb: RTL and testbench

Two-requester ICB arbiter placed directly in front of the `clint` slave port. It shares the timer/soft-interrupt register file between the core LSU (port m0) and the debug/system bus (port m1). Grants are round-robin, and a grant is locked until its command is accepted. Requester IDs are tracked in an in-order FIFO so each response returns to the master that issued it.

---
 rtl/clint_icb_arb_pkg.sv | 28 ++
 rtl/clint_arb_id_fifo.sv | 77 +++++++
 rtl/clint_icb_arb.sv | 147 ++++++++++++++
 tb/tb_clint_icb_arb.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_icb_arb_pkg.sv
// Shared types and helpers for the two-master ICB arbiter in front of the clint.
// Bus widths mirror the core's address and data widths.
package clint_icb_arb_pkg;

    localparam int ICB_ADDR_W    = 32;
    localparam int ICB_XLEN      = 32;
    localparam int ICB_MASK_W    = ICB_XLEN / 8;
    localparam int ARB_OUTS_DFLT = 2;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last_gnt);
        logic pick;
        if (v0 && v1) begin
            pick = ~last_gnt;
        end else if (v1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/clint_arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for outstanding clint commands.
// A same-cycle push and pop leaves the occupancy unchanged.
module clint_arb_id_fifo import clint_icb_arb_pkg::*; #(
    parameter int DEPTH = ARB_OUTS_DFLT,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             empty,
    output logic             head,
    output logic [CNT_W-1:0] cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= {DEPTH{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign empty = (cnt_q == {CNT_W{1'b0}});
    assign head  = mem_q[rd_ptr_q];
    assign cnt   = cnt_q;

endmodule

// File: rtl/clint_icb_arb.sv
// Round-robin arbiter sharing the clint ICB slave between the LSU (m0) and the debug bus (m1).
// Grants lock until accepted; an ID FIFO routes each response back to its issuer.
module clint_icb_arb import clint_icb_arb_pkg::*; #(
    parameter int OUTS_DEPTH = ARB_OUTS_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_icb_cmd_valid,
    output logic                  m0_icb_cmd_ready,
    input  logic [ICB_ADDR_W-1:0] m0_icb_cmd_addr,
    input  logic                  m0_icb_cmd_read,
    input  logic [ICB_XLEN-1:0]   m0_icb_cmd_wdata,
    input  logic [ICB_MASK_W-1:0] m0_icb_cmd_wmask,
    input  logic [1:0]            m0_icb_cmd_size,
    output logic                  m0_icb_rsp_valid,
    input  logic                  m0_icb_rsp_ready,
    output logic                  m0_icb_rsp_err,
    output logic [ICB_XLEN-1:0]   m0_icb_rsp_rdata,
    input  logic                  m1_icb_cmd_valid,
    output logic                  m1_icb_cmd_ready,
    input  logic [ICB_ADDR_W-1:0] m1_icb_cmd_addr,
    input  logic                  m1_icb_cmd_read,
    input  logic [ICB_XLEN-1:0]   m1_icb_cmd_wdata,
    input  logic [ICB_MASK_W-1:0] m1_icb_cmd_wmask,
    input  logic [1:0]            m1_icb_cmd_size,
    output logic                  m1_icb_rsp_valid,
    input  logic                  m1_icb_rsp_ready,
    output logic                  m1_icb_rsp_err,
    output logic [ICB_XLEN-1:0]   m1_icb_rsp_rdata,
    output logic                  clint_icb_cmd_valid,
    input  logic                  clint_icb_cmd_ready,
    output logic [ICB_ADDR_W-1:0] clint_icb_cmd_addr,
    output logic                  clint_icb_cmd_read,
    output logic [ICB_XLEN-1:0]   clint_icb_cmd_wdata,
    output logic [ICB_MASK_W-1:0] clint_icb_cmd_wmask,
    output logic [1:0]            clint_icb_cmd_size,
    input  logic                  clint_icb_rsp_valid,
    output logic                  clint_icb_rsp_ready,
    input  logic                  clint_icb_rsp_err,
    input  logic [ICB_XLEN-1:0]   clint_icb_rsp_rdata
);

    localparam int CNT_W = $clog2(OUTS_DEPTH + 1);

    arb_state_e       state_q, state_d;
    logic             lock_id_q, lock_id_d;
    logic             last_gnt_q, last_gnt_d;
    logic             gnt_id_s;
    logic             issue_ok_s;
    logic             cmd_accept_s;
    logic             rsp_pop_s;
    logic             fifo_empty_s;
    logic             fifo_head_s;
    logic [CNT_W-1:0] fifo_cnt_s;

    // Grant selection: held on the locked master until its command is taken.
    always_comb begin
        gnt_id_s = 1'b0;
        if (state_q == ARB_LOCKED) begin
            gnt_id_s = lock_id_q;
        end else begin
            gnt_id_s = rr_pick(m0_icb_cmd_valid, m1_icb_cmd_valid, last_gnt_q);
        end
    end

    // Issue is gated by the registered occupancy only, so a pop never frees a slot early.
    assign issue_ok_s          = (fifo_cnt_s != CNT_W'(OUTS_DEPTH));
    assign clint_icb_cmd_valid = (m0_icb_cmd_valid | m1_icb_cmd_valid) & issue_ok_s;
    assign cmd_accept_s        = clint_icb_cmd_valid & clint_icb_cmd_ready;
    assign m0_icb_cmd_ready    = ~gnt_id_s & clint_icb_cmd_ready & issue_ok_s;
    assign m1_icb_cmd_ready    =  gnt_id_s & clint_icb_cmd_ready & issue_ok_s;

    assign clint_icb_cmd_addr  = gnt_id_s ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign clint_icb_cmd_read  = gnt_id_s ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign clint_icb_cmd_wdata = gnt_id_s ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign clint_icb_cmd_wmask = gnt_id_s ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
    assign clint_icb_cmd_size  = gnt_id_s ? m1_icb_cmd_size  : m0_icb_cmd_size;

    // Lock and round-robin history next-state.
    always_comb begin
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (clint_icb_cmd_valid && !clint_icb_cmd_ready) begin
                    state_d   = ARB_LOCKED;
                    lock_id_d = gnt_id_s;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (cmd_accept_s) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_LOCKED;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (cmd_accept_s) begin
            last_gnt_d = gnt_id_s;
        end else begin
            last_gnt_d = last_gnt_q;
        end
    end

    // Arbiter state registers; m0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            lock_id_q  <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // With nothing outstanding the response is swallowed so a stale reply cannot hang clint.
    assign clint_icb_rsp_ready = fifo_empty_s ? 1'b1 :
                                 (fifo_head_s ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    assign rsp_pop_s           = clint_icb_rsp_valid & clint_icb_rsp_ready & ~fifo_empty_s;
    assign m0_icb_rsp_valid    = clint_icb_rsp_valid & ~fifo_head_s & ~fifo_empty_s;
    assign m1_icb_rsp_valid    = clint_icb_rsp_valid &  fifo_head_s & ~fifo_empty_s;
    assign m0_icb_rsp_err      = clint_icb_rsp_err;
    assign m1_icb_rsp_err      = clint_icb_rsp_err;
    assign m0_icb_rsp_rdata    = clint_icb_rsp_rdata;
    assign m1_icb_rsp_rdata    = clint_icb_rsp_rdata;

    clint_arb_id_fifo #(
        .DEPTH (OUTS_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_accept_s),
        .push_id (gnt_id_s),
        .pop     (rsp_pop_s),
        .empty   (fifo_empty_s),
        .head    (fifo_head_s),
        .cnt     (fifo_cnt_s)
    );

endmodule

// File: tb/tb_clint_icb_arb.sv
// Directed bench for clint_icb_arb with a one-cycle clint model behind it.
module tb_clint_icb_arb;
    import clint_icb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_icb_cmd_valid = 1'b0, m1_icb_cmd_valid = 1'b0;
    logic        m0_icb_cmd_ready, m1_icb_cmd_ready;
    logic [31:0] m0_icb_cmd_addr = 32'h0, m1_icb_cmd_addr = 32'h0;
    logic        m0_icb_cmd_read = 1'b1, m1_icb_cmd_read = 1'b1;
    logic [31:0] m0_icb_cmd_wdata = 32'h0, m1_icb_cmd_wdata = 32'h0;
    logic [3:0]  m0_icb_cmd_wmask = 4'hF, m1_icb_cmd_wmask = 4'hF;
    logic [1:0]  m0_icb_cmd_size = 2'd2, m1_icb_cmd_size = 2'd2;
    logic        m0_icb_rsp_valid, m1_icb_rsp_valid;
    logic        m0_icb_rsp_ready = 1'b1, m1_icb_rsp_ready = 1'b1;
    logic        m0_icb_rsp_err, m1_icb_rsp_err;
    logic [31:0] m0_icb_rsp_rdata, m1_icb_rsp_rdata;
    logic        clint_icb_cmd_valid;
    logic        clint_icb_cmd_ready = 1'b0;
    logic [31:0] clint_icb_cmd_addr;
    logic        clint_icb_cmd_read;
    logic [31:0] clint_icb_cmd_wdata;
    logic [3:0]  clint_icb_cmd_wmask;
    logic [1:0]  clint_icb_cmd_size;
    logic        clint_icb_rsp_valid;
    logic        clint_icb_rsp_ready;
    logic        clint_icb_rsp_err;
    logic [31:0] clint_icb_rsp_rdata;

    int nchk = 0;
    int nerr = 0;

    // clint model: 8-word register file, responses queued in order one cycle after accept
    logic        mdl_init = 1'b0;
    logic [31:0] mdl_mem [8];
    logic [31:0] q_data [8];
    logic [2:0]  q_wr = 3'd0;
    logic [2:0]  q_rd = 3'd0;

    assign clint_icb_rsp_valid = (q_wr != q_rd);
    assign clint_icb_rsp_rdata = q_data[q_rd];
    assign clint_icb_rsp_err   = 1'b0;

    always @(posedge clk) begin
        if (mdl_init) begin
            for (int i = 0; i < 8; i++) mdl_mem[i] <= 32'h100 + 32'(i);
        end else if (clint_icb_cmd_valid && clint_icb_cmd_ready && !clint_icb_cmd_read) begin
            mdl_mem[clint_icb_cmd_addr[4:2]] <= clint_icb_cmd_wdata;
        end
        if (clint_icb_cmd_valid && clint_icb_cmd_ready) begin
            q_data[q_wr] <= clint_icb_cmd_read ? mdl_mem[clint_icb_cmd_addr[4:2]] : 32'h0;
            q_wr         <= q_wr + 3'd1;
        end
        if (clint_icb_rsp_valid && clint_icb_rsp_ready) q_rd <= q_rd + 3'd1;
    end

    always #5 clk = ~clk;

    clint_icb_arb #(.OUTS_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
        .m0_icb_cmd_size(m0_icb_cmd_size), .m0_icb_rsp_valid(m0_icb_rsp_valid),
        .m0_icb_rsp_ready(m0_icb_rsp_ready), .m0_icb_rsp_err(m0_icb_rsp_err),
        .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
        .m1_icb_cmd_size(m1_icb_cmd_size), .m1_icb_rsp_valid(m1_icb_rsp_valid),
        .m1_icb_rsp_ready(m1_icb_rsp_ready), .m1_icb_rsp_err(m1_icb_rsp_err),
        .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
        .clint_icb_cmd_valid(clint_icb_cmd_valid), .clint_icb_cmd_ready(clint_icb_cmd_ready),
        .clint_icb_cmd_addr(clint_icb_cmd_addr), .clint_icb_cmd_read(clint_icb_cmd_read),
        .clint_icb_cmd_wdata(clint_icb_cmd_wdata), .clint_icb_cmd_wmask(clint_icb_cmd_wmask),
        .clint_icb_cmd_size(clint_icb_cmd_size), .clint_icb_rsp_valid(clint_icb_rsp_valid),
        .clint_icb_rsp_ready(clint_icb_rsp_ready), .clint_icb_rsp_err(clint_icb_rsp_err),
        .clint_icb_rsp_rdata(clint_icb_rsp_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic v, input logic rd, input logic [31:0] a, input logic [31:0] d);
        m0_icb_cmd_valid = v; m0_icb_cmd_read = rd; m0_icb_cmd_addr = a; m0_icb_cmd_wdata = d;
    endtask

    task automatic set_m1(input logic v, input logic rd, input logic [31:0] a, input logic [31:0] d);
        m1_icb_cmd_valid = v; m1_icb_cmd_read = rd; m1_icb_cmd_addr = a; m1_icb_cmd_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; mdl_init = 1'b1;
        cyc(); cyc();
        mdl_init = 1'b0;
        #1;
        nchk++;
        if ({m0_icb_rsp_valid, m1_icb_rsp_valid, clint_icb_rsp_ready, clint_icb_cmd_valid} !== 4'b0010) begin
            nerr++; $display("FAIL reset_state got=%b exp=0010",
                {m0_icb_rsp_valid, m1_icb_rsp_valid, clint_icb_rsp_ready, clint_icb_cmd_valid});
        end
        set_m1(1'b1, 1'b1, 32'h4, 32'h0);
        #1;
        nchk++;
        if ({clint_icb_cmd_valid, m1_icb_cmd_ready, clint_icb_cmd_addr} !== {1'b1, 1'b0, 32'h4}) begin
            nerr++; $display("FAIL reset_cmd_follow got=%h exp=%h",
                {clint_icb_cmd_valid, m1_icb_cmd_ready, clint_icb_cmd_addr}, {1'b1, 1'b0, 32'h4});
        end
        clint_icb_cmd_ready = 1'b1;
        #1;
        nchk++;
        if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b01) begin
            nerr++; $display("FAIL reset_ready got=%b exp=01", {m0_icb_cmd_ready, m1_icb_cmd_ready});
        end
        clint_icb_cmd_ready = 1'b0;
        set_m1(1'b0, 1'b1, 32'h0, 32'h0);
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic exp_g;
        logic prev_g;
        exp_g  = 1'b0;
        prev_g = 1'b0;
        clint_icb_cmd_ready = 1'b1;
        set_m0(1'b1, 1'b1, 32'h0, 32'h0);
        set_m1(1'b1, 1'b1, 32'h4, 32'h0);
        for (int i = 0; i < 8; i++) begin
            #1;
            nchk++;
            if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== {~exp_g, exp_g}) begin
                nerr++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i,
                    {m0_icb_cmd_ready, m1_icb_cmd_ready}, {~exp_g, exp_g});
            end
            if (i > 0) begin
                nchk++;
                if ({m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_rdata} !==
                    {~prev_g, prev_g, (prev_g ? 32'h101 : 32'h100)}) begin
                    nerr++; $display("FAIL rr_rsp[%0d] got=%h exp=%h", i,
                        {m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_rdata},
                        {~prev_g, prev_g, (prev_g ? 32'h101 : 32'h100)});
                end
            end
            cyc();
            prev_g = exp_g;
            exp_g  = ~exp_g;
        end
        set_m0(1'b0, 1'b1, 32'h0, 32'h0);
        set_m1(1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        nchk++;
        if ({m0_icb_rsp_valid, m1_icb_rsp_valid, m1_icb_rsp_rdata} !== {1'b0, 1'b1, 32'h101}) begin
            nerr++; $display("FAIL rr_last_rsp got=%h exp=%h",
                {m0_icb_rsp_valid, m1_icb_rsp_valid, m1_icb_rsp_rdata}, {1'b0, 1'b1, 32'h101});
        end
        cyc();
    endtask

    task automatic test_lock();
        clint_icb_cmd_ready = 1'b0;
        set_m1(1'b1, 1'b0, 32'h10, 32'h55);
        #1;
        nchk++;
        if ({clint_icb_cmd_valid, m1_icb_cmd_ready, clint_icb_cmd_addr} !== {1'b1, 1'b0, 32'h10}) begin
            nerr++; $display("FAIL lock_req got=%h exp=%h",
                {clint_icb_cmd_valid, m1_icb_cmd_ready, clint_icb_cmd_addr}, {1'b1, 1'b0, 32'h10});
        end
        repeat (3) cyc();
        set_m0(1'b1, 1'b1, 32'h8, 32'h0);
        #1;
        nchk++;
        if ({clint_icb_cmd_addr, clint_icb_cmd_wdata, clint_icb_cmd_read, m0_icb_cmd_ready, m1_icb_cmd_ready}
            !== {32'h10, 32'h55, 3'b000}) begin
            nerr++; $display("FAIL lock_hold got=%h exp=%h",
                {clint_icb_cmd_addr, clint_icb_cmd_wdata, clint_icb_cmd_read, m0_icb_cmd_ready, m1_icb_cmd_ready},
                {32'h10, 32'h55, 3'b000});
        end
        cyc();
        clint_icb_cmd_ready = 1'b1;
        #1;
        nchk++;
        if ({m0_icb_cmd_ready, m1_icb_cmd_ready, clint_icb_cmd_addr} !== {2'b01, 32'h10}) begin
            nerr++; $display("FAIL lock_accept got=%h exp=%h",
                {m0_icb_cmd_ready, m1_icb_cmd_ready, clint_icb_cmd_addr}, {2'b01, 32'h10});
        end
        cyc();
        set_m1(1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        nchk++;
        if ({m1_icb_rsp_valid, m0_icb_rsp_valid, m0_icb_cmd_ready, clint_icb_cmd_addr} !== {3'b101, 32'h8}) begin
            nerr++; $display("FAIL lock_next_m0 got=%h exp=%h",
                {m1_icb_rsp_valid, m0_icb_rsp_valid, m0_icb_cmd_ready, clint_icb_cmd_addr}, {3'b101, 32'h8});
        end
        cyc();
        set_m0(1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        nchk++;
        if ({m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_rdata} !== {2'b10, 32'h102}) begin
            nerr++; $display("FAIL lock_m0_rsp got=%h exp=%h",
                {m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_rdata}, {2'b10, 32'h102});
        end
        cyc();
    endtask

    task automatic test_single_master();
        set_m0(1'b1, 1'b0, 32'h8, 32'h10);
        #1;
        nchk++;
        if ({clint_icb_cmd_valid, clint_icb_cmd_addr, clint_icb_cmd_wdata, clint_icb_cmd_read,
             clint_icb_cmd_wmask, clint_icb_cmd_size, m0_icb_cmd_ready, m1_icb_cmd_ready}
            !== {1'b1, 32'h8, 32'h10, 1'b0, 4'hF, 2'd2, 2'b10}) begin
            nerr++; $display("FAIL single_wr_cmd got=%h exp=%h",
                {clint_icb_cmd_valid, clint_icb_cmd_addr, clint_icb_cmd_wdata, clint_icb_cmd_read,
                 clint_icb_cmd_wmask, clint_icb_cmd_size, m0_icb_cmd_ready, m1_icb_cmd_ready},
                {1'b1, 32'h8, 32'h10, 1'b0, 4'hF, 2'd2, 2'b10});
        end
        cyc();
        set_m0(1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        nchk++;
        if ({m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_err} !== 3'b100) begin
            nerr++; $display("FAIL single_wr_rsp got=%b exp=100",
                {m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_err});
        end
        cyc();
        set_m0(1'b1, 1'b1, 32'h8, 32'h0);
        #1;
        nchk++;
        if ({m0_icb_cmd_ready, m0_icb_rsp_valid, m1_icb_rsp_valid} !== 3'b100) begin
            nerr++; $display("FAIL single_rd_cmd got=%b exp=100",
                {m0_icb_cmd_ready, m0_icb_rsp_valid, m1_icb_rsp_valid});
        end
        cyc();
        set_m0(1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        nchk++;
        if ({m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_rdata} !== {2'b10, 32'h10}) begin
            nerr++; $display("FAIL single_rd_rsp got=%h exp=%h",
                {m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_rdata}, {2'b10, 32'h10});
        end
        cyc();
    endtask

    task automatic test_back_pressure();
        m0_icb_rsp_ready = 1'b0;
        m1_icb_rsp_ready = 1'b0;
        set_m0(1'b1, 1'b1, 32'h8, 32'h0);
        set_m1(1'b1, 1'b1, 32'h10, 32'h0);
        #1;
        nchk++;
        if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b01) begin
            nerr++; $display("FAIL bp_first_gnt got=%b exp=01", {m0_icb_cmd_ready, m1_icb_cmd_ready});
        end
        cyc();
        #1;
        nchk++;
        if ({m0_icb_cmd_ready, m1_icb_cmd_ready, clint_icb_cmd_valid, m1_icb_rsp_valid, clint_icb_rsp_ready}
            !== 5'b10110) begin
            nerr++; $display("FAIL bp_second got=%b exp=10110",
                {m0_icb_cmd_ready, m1_icb_cmd_ready, clint_icb_cmd_valid, m1_icb_rsp_valid, clint_icb_rsp_ready});
        end
        cyc();
        #1;
        nchk++;
        if ({clint_icb_cmd_valid, m0_icb_cmd_ready, m1_icb_cmd_ready, m1_icb_rsp_valid, m0_icb_rsp_valid,
             clint_icb_rsp_ready} !== 6'b000100) begin
            nerr++; $display("FAIL bp_full got=%b exp=000100",
                {clint_icb_cmd_valid, m0_icb_cmd_ready, m1_icb_cmd_ready, m1_icb_rsp_valid, m0_icb_rsp_valid,
                 clint_icb_rsp_ready});
        end
        repeat (2) cyc();
        nchk++;
        if (clint_icb_cmd_valid !== 1'b0) begin
            nerr++; $display("FAIL bp_still_full got=%b exp=0", clint_icb_cmd_valid);
        end
    endtask

    task automatic test_full_pop_push();
        m1_icb_rsp_ready = 1'b1;
        #1;
        nchk++;
        if ({clint_icb_cmd_valid, clint_icb_rsp_ready, m1_icb_rsp_valid, m1_icb_rsp_rdata} !== {3'b011, 32'h55}) begin
            nerr++; $display("FAIL fpp_no_bypass got=%h exp=%h",
                {clint_icb_cmd_valid, clint_icb_rsp_ready, m1_icb_rsp_valid, m1_icb_rsp_rdata}, {3'b011, 32'h55});
        end
        cyc();
        m0_icb_rsp_ready = 1'b1;
        #1;
        nchk++;
        if ({clint_icb_cmd_valid, m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_rdata, m0_icb_cmd_ready,
             m1_icb_cmd_ready} !== {3'b110, 32'h10, 2'b01}) begin
            nerr++; $display("FAIL fpp_head_m0 got=%h exp=%h",
                {clint_icb_cmd_valid, m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_rdata, m0_icb_cmd_ready,
                 m1_icb_cmd_ready}, {3'b110, 32'h10, 2'b01});
        end
        cyc();
        set_m1(1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        nchk++;
        if ({clint_icb_cmd_valid, m1_icb_rsp_valid, m0_icb_rsp_valid, m1_icb_rsp_rdata} !== {3'b110, 32'h55}) begin
            nerr++; $display("FAIL fpp_cnt_kept got=%h exp=%h",
                {clint_icb_cmd_valid, m1_icb_rsp_valid, m0_icb_rsp_valid, m1_icb_rsp_rdata}, {3'b110, 32'h55});
        end
        set_m0(1'b0, 1'b1, 32'h0, 32'h0);
        cyc();
        #1;
        nchk++;
        if ({m0_icb_rsp_valid, m1_icb_rsp_valid, clint_icb_rsp_ready, clint_icb_rsp_valid} !== 4'b0010) begin
            nerr++; $display("FAIL fpp_drained got=%b exp=0010",
                {m0_icb_rsp_valid, m1_icb_rsp_valid, clint_icb_rsp_ready, clint_icb_rsp_valid});
        end
    endtask

    task automatic test_reset_mid();
        m0_icb_rsp_ready = 1'b0;
        set_m0(1'b1, 1'b1, 32'h8, 32'h0);
        #1;
        nchk++;
        if (m0_icb_cmd_ready !== 1'b1) begin
            nerr++; $display("FAIL rmid_issue got=%b exp=1", m0_icb_cmd_ready);
        end
        cyc();
        set_m0(1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        nchk++;
        if ({m0_icb_rsp_valid, clint_icb_rsp_ready} !== 2'b10) begin
            nerr++; $display("FAIL rmid_pending got=%b exp=10", {m0_icb_rsp_valid, clint_icb_rsp_ready});
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        nchk++;
        if ({m0_icb_rsp_valid, m1_icb_rsp_valid, clint_icb_rsp_ready, clint_icb_rsp_valid} !== 4'b0011) begin
            nerr++; $display("FAIL rmid_stale_drop got=%b exp=0011",
                {m0_icb_rsp_valid, m1_icb_rsp_valid, clint_icb_rsp_ready, clint_icb_rsp_valid});
        end
        cyc();
        nchk++;
        if (clint_icb_rsp_valid !== 1'b0) begin
            nerr++; $display("FAIL rmid_stale_gone got=%b exp=0", clint_icb_rsp_valid);
        end
        m0_icb_rsp_ready = 1'b1;
        set_m1(1'b1, 1'b1, 32'h10, 32'h0);
        #1;
        nchk++;
        if ({m1_icb_cmd_ready, m0_icb_cmd_ready} !== 2'b10) begin
            nerr++; $display("FAIL rmid_m1_gnt got=%b exp=10", {m1_icb_cmd_ready, m0_icb_cmd_ready});
        end
        cyc();
        set_m1(1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        nchk++;
        if ({m1_icb_rsp_valid, m0_icb_rsp_valid, m1_icb_rsp_rdata} !== {2'b10, 32'h55}) begin
            nerr++; $display("FAIL rmid_m1_rsp got=%h exp=%h",
                {m1_icb_rsp_valid, m0_icb_rsp_valid, m1_icb_rsp_rdata}, {2'b10, 32'h55});
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_single_master();
        test_back_pressure();
        test_full_pop_push();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
